shift_issue_queue: RTL and testbench

Operand-buffering issue stage that sits directly upstream of the combinational shift stage (result = low W bits of sign-extended x shifted left by y). Buffers incoming (x, y) operand pairs in a small FIFO, presents the head pair to the shifter, and captures the shifter's result into a registered valid/ready output port. It decouples the bursty operand producer from the result consumer and holds throughput at one result per cycle.

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_operand_fifo.sv | 67 ++++++
 rtl/shift_issue_queue.sv | 62 ++++++
 tb/tb_shift_issue_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared defaults and the operand-pair type for the shift issue stage.
package shift_pkg;

  localparam int SHIFT_DEPTH = 4;
  localparam int SHIFT_W     = 8;
  localparam int SHIFT_SW    = 8;

  typedef struct packed {
    logic [SHIFT_W-1:0]  x;
    logic [SHIFT_SW-1:0] y;
  } operand_pair_t;

endpackage

// File: rtl/shift_operand_fifo.sv
// Operand-pair FIFO: storage, pointers, occupancy count and head read.
// Latency: a pushed pair is visible on head_x/head_y the cycle after the push edge.
// Backpressure: push_ready drops only when count == DEPTH; never depends on pop.
module shift_operand_fifo
  import shift_pkg::*;
#(
  parameter int DEPTH = SHIFT_DEPTH,
  parameter int W     = SHIFT_W,
  parameter int SW    = SHIFT_SW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [W-1:0]  push_x,
  input  logic [SW-1:0] push_y,
  input  logic          pop,
  output logic [W-1:0]  head_x,
  output logic [SW-1:0] head_y,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [W-1:0]  x;
    logic [SW-1:0] y;
  } pair_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  pair_t          mem [DEPTH];
  pair_t          head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_q;
  logic           push;

  assign push_ready = (count_q != FULL);
  assign push       = push_valid && push_ready;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{x: push_x, y: push_y};
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  assign head   = mem[rd_ptr];
  assign head_x = (count_q != '0) ? head.x : '0;
  assign head_y = (count_q != '0) ? head.y : '0;
  assign count  = count_q;

endmodule

// File: rtl/shift_issue_queue.sv
// Issue stage: buffers (x, y) pairs, feeds the head to an external shifter, registers its result.
// Latency: accept at edge N, head on shifter in cycle N+1, out_valid from cycle N+2.
// Backpressure: out_ready=0 holds out_data/out_valid; queue keeps accepting until full.
module shift_issue_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = SHIFT_DEPTH,
  parameter int W     = SHIFT_W,
  parameter int SW    = SHIFT_SW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_x,
  input  logic [SW-1:0]            in_y,
  output logic [W-1:0]             sh_x,
  output logic [SW-1:0]            sh_y,
  input  logic [W-1:0]             sh_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count
);

  logic slot_free;
  logic issue;

  assign slot_free = !out_valid || out_ready;
  assign issue     = (count != '0) && slot_free;

  shift_operand_fifo #(
    .DEPTH (DEPTH),
    .W     (W),
    .SW    (SW)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_x     (in_x),
    .push_y     (in_y),
    .pop        (issue),
    .head_x     (sh_x),
    .head_y     (sh_y),
    .count      (count)
  );

  // Result register: load on issue, otherwise clear valid once consumed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= sh_res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Directed bench for shift_issue_queue with a behavioural shifter on the sh_* loop.
module tb_shift_issue_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic [7:0] sh_x;
  logic [7:0] sh_y;
  logic [7:0] sh_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  shift_issue_queue #(.DEPTH(4), .W(8), .SW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .sh_x      (sh_x),
    .sh_y      (sh_y),
    .sh_res    (sh_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Left shift of the sign-extended operand keeps only the low bits, so sign is irrelevant.
  assign sh_res = sh_x << sh_y;

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_x      = 8'hAA;
    in_y      = 8'h01;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_sh_x", 32'(sh_x), 0);
    check("rst_sh_y", 32'(sh_y), 0);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();

    // Single pair, 2-cycle latency, no bypass.
    offer(8'h03, 8'd2);
    tick();
    in_valid = 1'b0;
    check("t1_count", 32'(count), 1);
    check("t1_sh_x", 32'(sh_x), 32'h03);
    check("t1_sh_y", 32'(sh_y), 2);
    check("t1_no_bypass", 32'(out_valid), 0);
    tick();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'h0C);
    check("t1_count0", 32'(count), 0);
    tick();
    check("t1_drained", 32'(out_valid), 0);
    check("t1_data_held", 32'(out_data), 32'h0C);

    // Back-to-back pairs, including a shift amount beyond the width.
    offer(8'h81, 8'd1);
    tick();
    offer(8'h40, 8'd200);
    tick();
    in_valid = 1'b0;
    check("t2_data0", 32'(out_data), 32'h02);
    check("t2_valid0", 32'(out_valid), 1);
    tick();
    check("t2_data1", 32'(out_data), 32'h00);
    check("t2_valid1", 32'(out_valid), 1);
    tick();
    check("t2_drained", 32'(out_valid), 0);

    // Fill under backpressure: 4 queued plus 1 in the result register.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      offer(8'h11 + 8'(k), 8'(k));
      tick();
    end
    in_valid = 1'b0;
    check("t3_full_count", 32'(count), 4);
    check("t3_full_ready", 32'(in_ready), 0);
    check("t3_head_data", 32'(out_data), 32'h11);
    tick();
    check("t3_hold_data", 32'(out_data), 32'h11);
    check("t3_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    #1;
    check("t3_no_comb_ready", 32'(in_ready), 0);
    tick();
    check("t3_drain1", 32'(out_data), 32'h24);
    check("t3_cnt1", 32'(count), 3);
    tick();
    check("t3_drain2", 32'(out_data), 32'h4C);
    tick();
    check("t3_drain3", 32'(out_data), 32'hA0);
    tick();
    check("t3_drain4", 32'(out_data), 32'h50);
    check("t3_cnt4", 32'(count), 0);
    tick();
    check("t3_empty", 32'(out_valid), 0);

    // Full queue with in_valid held and out_ready toggling; A_k = (0x20+k, 1) -> 0x40+2k.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      offer(8'h20 + 8'(k), 8'd1);
      tick();
    end
    offer(8'h25, 8'd1);
    check("t4_full", 32'(count), 4);
    check("t4_data_a0", 32'(out_data), 32'h40);
    out_ready = 1'b1;
    tick();
    check("t4_e6_count", 32'(count), 3);
    check("t4_e6_data", 32'(out_data), 32'h42);
    out_ready = 1'b0;
    tick();
    check("t4_e7_count", 32'(count), 4);
    check("t4_e7_data", 32'(out_data), 32'h42);
    offer(8'h26, 8'd1);
    out_ready = 1'b1;
    tick();
    check("t4_e8_count", 32'(count), 3);
    check("t4_e8_data", 32'(out_data), 32'h44);
    out_ready = 1'b0;
    tick();
    check("t4_e9_count", 32'(count), 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 3; k < 7; k++) begin
      tick();
      check("t4_order", 32'(out_data), 32'h40 + 32'(2 * k));
      check("t4_count", 32'(count), 32'(6 - k));
    end
    tick();
    check("t4_empty", 32'(out_valid), 0);

    // Steady push+issue at count 2; B_k = (0x30+k, 2) -> 0xC0+4k.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(8'h30 + 8'(k), 8'd2);
      tick();
    end
    check("t5_pre_count", 32'(count), 2);
    check("t5_pre_data", 32'(out_data), 32'hC0);
    out_ready = 1'b1;
    for (int k = 3; k < 13; k++) begin
      offer(8'h30 + 8'(k), 8'd2);
      tick();
      check("t5_count", 32'(count), 2);
      check("t5_data", 32'(out_data), 32'hC0 + 32'(4 * (k - 2)));
    end

    // Mid-operation reset at count 3 with a held result.
    out_ready = 1'b0;
    offer(8'h3D, 8'd2);
    tick();
    check("t6_pre_count", 32'(count), 3);
    check("t6_pre_valid", 32'(out_valid), 1);
    reset = 1'b0;
    offer(8'h7F, 8'd3);
    tick();
    check("t6_count", 32'(count), 0);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_data", 32'(out_data), 0);
    check("t6_sh_x", 32'(sh_x), 0);
    check("t6_sh_y", 32'(sh_y), 0);
    check("t6_in_ready", 32'(in_ready), 1);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("t6_post_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
